// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: per-unit 2-entry result FIFOs drained onto CDB_PORTS
// broadcast lanes by a round-robin scan that grants each unit at most one lane per cycle.
module cdb_arbiter #(
    parameter int ROB_DEPTH = 4,
    parameter int FU_COUNT  = 4,
    parameter int CDB_PORTS = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
    input  logic [FU_COUNT-1:0]  fu_valid,
    output logic [FU_COUNT-1:0]  fu_ready,
    input  logic [ROB_DEPTH-1:0] fu_rob [FU_COUNT],
    input  logic [4:0]           fu_rd_s [FU_COUNT],
    input  logic [31:0]          fu_rd_v [FU_COUNT],
    output logic [CDB_PORTS-1:0] cdb_valid_out,
    output logic [ROB_DEPTH-1:0] cdb_rob [CDB_PORTS],
    output logic [4:0]           cdb_rd_s [CDB_PORTS],
    output logic [31:0]          cdb_rd_v [CDB_PORTS]
);

    localparam int PTR_W = (FU_COUNT > 1) ? $clog2(FU_COUNT) : 1;

    typedef struct packed {
        logic [ROB_DEPTH-1:0] rob;
        logic [4:0]           rd_s;
        logic [31:0]          rd_v;
    } ent_t;

    ent_t                 mem [FU_COUNT][2];
    logic [1:0]           count [FU_COUNT];
    logic [FU_COUNT-1:0]  head;
    logic [FU_COUNT-1:0]  tail;
    logic [PTR_W-1:0]     rr_ptr;
    logic [PTR_W-1:0]     rr_next;
    logic [FU_COUNT-1:0]  grant;
    logic [FU_COUNT-1:0]  push;
    logic [CDB_PORTS-1:0] lane_vld;
    logic [PTR_W-1:0]     lane_unit [CDB_PORTS];
    logic                 kill;

    // rst and flush both cut the handshake and the broadcast in the same cycle
    assign kill = rst || flush;

    always_comb begin
        for (int i = 0; i < FU_COUNT; i++) begin
            fu_ready[i] = !kill && (count[i] != 2'd2);
        end
    end

    assign push = fu_valid & fu_ready;

    // Arbitration stage: purely from registered occupancy and rr_ptr
    always_comb begin
        logic [PTR_W-1:0] idx;
        int               seen;
        grant    = '0;
        lane_vld = '0;
        rr_next  = rr_ptr;
        idx      = '0;
        seen     = 0;
        for (int k = 0; k < CDB_PORTS; k++) begin
            lane_unit[k] = '0;
        end
        for (int j = 0; j < FU_COUNT; j++) begin
            idx = PTR_W'((int'(rr_ptr) + j) % FU_COUNT);
            if (!kill && (count[idx] != 2'd0) && (seen < CDB_PORTS)) begin
                grant[idx] = 1'b1;
                for (int k = 0; k < CDB_PORTS; k++) begin
                    if (seen == k) begin
                        lane_vld[k]  = 1'b1;
                        lane_unit[k] = idx;
                    end
                end
                rr_next = PTR_W'((int'(idx) + 1) % FU_COUNT);
                seen    = seen + 1;
            end
        end
    end

    always_comb begin
        ent_t e;
        for (int k = 0; k < CDB_PORTS; k++) begin
            e                = mem[lane_unit[k]][head[lane_unit[k]]];
            cdb_valid_out[k] = lane_vld[k];
            cdb_rob[k]       = lane_vld[k] ? e.rob  : '0;
            cdb_rd_s[k]      = lane_vld[k] ? e.rd_s : '0;
            cdb_rd_v[k]      = lane_vld[k] ? e.rd_v : '0;
        end
    end

    // FIFO control state stage
    always_ff @(posedge clk) begin
        if (kill) begin
            rr_ptr <= '0;
            head   <= '0;
            tail   <= '0;
            for (int i = 0; i < FU_COUNT; i++) begin
                count[i] <= 2'd0;
            end
        end else begin
            if (grant != '0) begin
                rr_ptr <= rr_next;
            end
            for (int i = 0; i < FU_COUNT; i++) begin
                if (push[i]) begin
                    tail[i] <= ~tail[i];
                end
                if (grant[i]) begin
                    head[i] <= ~head[i];
                end
                if (push[i] && !grant[i]) begin
                    count[i] <= count[i] + 2'd1;
                end else if (!push[i] && grant[i]) begin
                    count[i] <= count[i] - 2'd1;
                end
            end
        end
    end

    // Payload storage is only ever read behind a nonzero count, so it needs no reset
    always_ff @(posedge clk) begin
        for (int i = 0; i < FU_COUNT; i++) begin
            if (push[i]) begin
                mem[i][tail[i]] <= {fu_rob[i], fu_rd_s[i], fu_rd_v[i]};
            end
        end
    end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Randomized and directed bench for cdb_arbiter against a queue-based model of the
// per-unit FIFOs and the round-robin lane assignment.
module tb_cdb_arbiter;

    localparam int RW = 4;
    localparam int NF = 4;
    localparam int NP = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          flush;
    logic [NF-1:0] fu_valid;
    logic [NF-1:0] fu_ready;
    logic [RW-1:0] fu_rob [NF];
    logic [4:0]    fu_rd_s [NF];
    logic [31:0]   fu_rd_v [NF];
    logic [NP-1:0] cdb_valid_out;
    logic [RW-1:0] cdb_rob [NP];
    logic [4:0]    cdb_rd_s [NP];
    logic [31:0]   cdb_rd_v [NP];

    cdb_arbiter #(.ROB_DEPTH(RW), .FU_COUNT(NF), .CDB_PORTS(NP)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .fu_valid(fu_valid), .fu_ready(fu_ready),
        .fu_rob(fu_rob), .fu_rd_s(fu_rd_s), .fu_rd_v(fu_rd_v),
        .cdb_valid_out(cdb_valid_out), .cdb_rob(cdb_rob),
        .cdb_rd_s(cdb_rd_s), .cdb_rd_v(cdb_rd_v)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [RW-1:0] rob;
        logic [4:0]    rds;
        logic [31:0]   rdv;
    } ent_t;

    ent_t          q [NF][$];
    int            m_rr = 0;
    logic [NF-1:0] m_grant;
    logic [NF-1:0] m_acc;
    int            gcount [NF];
    int            n_pass = 0;
    int            n_total = 0;
    bit            rec_on = 0;
    bit            saw_nr = 0;
    logic [RW-1:0] obs0 [$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    endtask

    task automatic idle();
        fu_valid = '0;
        for (int u = 0; u < NF; u++) begin
            fu_rob[u] = '0; fu_rd_s[u] = '0; fu_rd_v[u] = '0;
        end
    endtask

    task automatic drive(input int u, input logic [RW-1:0] rob, input logic [4:0] rds, input logic [31:0] rdv);
        fu_valid[u] = 1'b1;
        fu_rob[u]   = rob;
        fu_rd_s[u]  = rds;
        fu_rd_v[u]  = rdv;
    endtask

    // One clock: check outputs mid-cycle, then advance the model at the edge
    task automatic step();
        ent_t exp_q [$];
        int   last;
        int   u;
        @(negedge clk);
        m_grant = '0;
        if (!rst && !flush) begin
            for (int j = 0; j < NF; j++) begin
                u = (m_rr + j) % NF;
                if (q[u].size() > 0 && exp_q.size() < NP) begin
                    m_grant[u] = 1'b1;
                    exp_q.push_back(q[u][0]);
                end
            end
        end
        for (int k = 0; k < NP; k++) begin
            if (k < exp_q.size()) begin
                check($sformatf("lane%0d_valid", k), 64'(cdb_valid_out[k]), 64'd1);
                check($sformatf("lane%0d_rob", k), 64'(cdb_rob[k]), 64'(exp_q[k].rob));
                check($sformatf("lane%0d_rds", k), 64'(cdb_rd_s[k]), 64'(exp_q[k].rds));
                check($sformatf("lane%0d_rdv", k), 64'(cdb_rd_v[k]), 64'(exp_q[k].rdv));
            end else begin
                check($sformatf("lane%0d_idle", k),
                      {27'd0, cdb_valid_out[k], cdb_rob[k], cdb_rd_s[k], cdb_rd_v[k]}, 64'd0);
            end
            if (cdb_valid_out[k] === 1'b1) begin
                if (cdb_rd_s[k] < NF) gcount[cdb_rd_s[k]]++;
                if (rec_on && cdb_rd_s[k] == 5'd0) obs0.push_back(cdb_rob[k]);
            end
        end
        for (int i = 0; i < NF; i++) begin
            check($sformatf("ready%0d", i), 64'(fu_ready[i]),
                  64'(!rst && !flush && q[i].size() < 2));
        end
        if (rec_on && fu_ready[0] === 1'b0) saw_nr = 1;
        check("rr_ptr", 64'(dut.rr_ptr), 64'(m_rr));
        @(posedge clk);
        for (int i = 0; i < NF; i++) begin
            m_acc[i] = fu_valid[i] && !rst && !flush && q[i].size() < 2;
        end
        if (rst || flush) begin
            for (int i = 0; i < NF; i++) q[i].delete();
            m_rr = 0;
        end else begin
            last = -1;
            for (int j = 0; j < NF; j++) begin
                u = (m_rr + j) % NF;
                if (m_grant[u]) last = u;
            end
            for (int i = 0; i < NF; i++) begin
                if (m_grant[i]) void'(q[i].pop_front());
                if (m_acc[i]) q[i].push_back('{rob: fu_rob[i], rds: fu_rd_s[i], rdv: fu_rd_v[i]});
            end
            if (last >= 0) m_rr = (last + 1) % NF;
        end
        #1;
    endtask

    task automatic stream_all();
        for (int u = 0; u < NF; u++) begin
            drive(u, RW'($urandom), 5'(u), $urandom);
        end
    endtask

    initial begin
        int bp;
        for (int i = 0; i < NF; i++) gcount[i] = 0;
        rst = 1'b1; flush = 1'b0;
        idle();
        repeat (3) step();

        // single result from unit 2
        rst = 1'b0;
        step();
        drive(2, 4'd5, 5'd7, 32'hDEADBEEF);
        step();
        idle();
        step();
        step();
        check("single_rr", 64'(dut.rr_ptr), 64'd3);

        // all four units fire together from rr_ptr=0
        flush = 1'b1;
        step();
        flush = 1'b0;
        for (int u = 0; u < NF; u++) drive(u, RW'(u + 8), 5'(u), 32'h1000 + u);
        step();
        idle();
        repeat (3) step();
        check("all4_rr", 64'(dut.rr_ptr), 64'd0);

        // backpressure on unit 0 while the others stream
        rec_on = 1; bp = 0;
        for (int c = 0; c < 40 && (bp < 3 || q[0].size() > 0); c++) begin
            stream_all();
            if (bp < 3) drive(0, RW'(bp + 1), 5'd0, 32'hB0 + bp);
            else fu_valid[0] = 1'b0;
            step();
            if (m_acc[0]) bp++;
        end
        rec_on = 0;
        idle();
        repeat (3) step();
        check("bp_ready_drop", 64'(saw_nr), 64'd1);
        check("bp_count", 64'(obs0.size()), 64'd3);
        for (int i = 0; i < 3 && i < obs0.size(); i++) begin
            check($sformatf("bp_order%0d", i), 64'(obs0[i]), 64'(i + 1));
        end

        // fairness over 8 cycles of continuous streaming
        flush = 1'b1;
        step();
        flush = 1'b0;
        stream_all();
        step();
        for (int i = 0; i < NF; i++) gcount[i] = 0;
        repeat (8) begin
            stream_all();
            step();
        end
        for (int i = 0; i < NF; i++) begin
            check($sformatf("fair%0d", i), 64'(gcount[i]), 64'd4);
        end

        // flush with buffered entries
        repeat (3) begin
            stream_all();
            step();
        end
        check("pre_flush_occ", 64'(q[0].size() + q[1].size() > 0), 64'd1);
        flush = 1'b1;
        step();
        flush = 1'b0;
        idle();
        step();
        check("flush_rr", 64'(dut.rr_ptr), 64'd0);
        check("flush_ready", 64'(fu_ready), 64'hF);
        step();

        // reset in the middle of streaming
        repeat (3) begin
            stream_all();
            step();
        end
        rst = 1'b1;
        repeat (2) step();
        rst = 1'b0;
        idle();
        drive(3, 4'd9, 5'd3, 32'h33);
        step();
        idle();
        step();
        step();

        // randomized traffic with occasional flush and reset
        for (int c = 0; c < 400; c++) begin
            idle();
            for (int u = 0; u < NF; u++) begin
                if ($urandom_range(3) != 0) drive(u, RW'($urandom), 5'($urandom), $urandom);
            end
            flush = ($urandom_range(31) == 0);
            rst   = ($urandom_range(63) == 0);
            step();
        end
        rst = 1'b0; flush = 1'b0;
        idle();
        repeat (4) step();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/cdb_arbiter.md
# cdb_arbiter

Collects finished results from the execution units and broadcasts them on the common data bus (CDB) that the reorder buffer and reservation stations snoop. Each unit owns a 2-entry result FIFO. Each cycle a round-robin arbiter grants up to CDB_PORTS distinct units one broadcast lane each. Sits between the functional units (producers) and the ROB's CDB write ports (consumers).

## Interface
- ROB_DEPTH, 4, bit width of a ROB index
- FU_COUNT, 4, number of execution units feeding the CDB (≥ CDB_PORTS)
- CDB_PORTS, 2, number of parallel broadcast lanes (≥ 1)

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- flush  in  1  mispredict flush; discard all buffered results
- fu_valid[FU_COUNT]  in  1  unit i presents a result
- fu_ready[FU_COUNT]  out  1  unit i's FIFO can accept this cycle
- fu_rob[FU_COUNT]  in  ROB_DEPTH  ROB index of the result
- fu_rd_s[FU_COUNT]  in  5  architectural destination register
- fu_rd_v[FU_COUNT]  in  32  result value
- cdb_valid_out[CDB_PORTS]  out  1  lane k carries a broadcast this cycle
- cdb_rob[CDB_PORTS]  out  ROB_DEPTH  ROB index on lane k
- cdb_rd_s[CDB_PORTS]  out  5  destination register on lane k
- cdb_rd_v[CDB_PORTS]  out  32  value on lane k

## Operation
- Per-unit FIFO: 2 entries, a 2-bit count (0..2), and head/tail bits that wrap.
- Per-unit handshake:
  - fu_ready[i] = !rst && !flush && count[i] < 2. It does not depend on fu_valid or on a same-cycle pop; there is no pass-through.
  - An entry is accepted when fu_valid[i] && fu_ready[i], and is written at the clock edge.
- Arbitration (combinational from registered state only):
  - Scan units rr_ptr, rr_ptr+1, … modulo FU_COUNT.
  - The first non-empty unit gets lane 0, the next non-empty unit gets lane 1, and so on, up to CDB_PORTS lanes.
  - A unit wins at most one lane per cycle. Only its head entry pops.
- Lane outputs:
  - A granted lane drives the head fields of its unit, with cdb_valid_out=1.
  - An ungranted lane drives cdb_valid_out=0 and all-zero data.
- Pop: every granted head pops at the clock edge. The consumer is always-ready; there is no back-pressure on the CDB.
- rr_ptr (width $clog2(FU_COUNT)):
  - After any grant, it becomes (index of the last granted unit + 1) mod FU_COUNT.
  - It is unchanged when nothing is granted.
- Simultaneous push and pop on the same FIFO: count is unchanged and both take effect. This is only possible when count was 1, since a full FIFO is not ready.
- Ordering: results from one unit broadcast in acceptance order. There is no ordering across units.
- Flush:
  - In the flush cycle, all cdb_valid_out are forced to 0 and all fu_ready to 0.
  - At the edge, every FIFO empties and rr_ptr returns to 0.
  - Results presented during flush are dropped.

## Timing
- Reset values (while rst high and after it falls):
  - count=0 and rr_ptr=0.
  - cdb_valid_out=0 with zero data on all lanes.
  - fu_ready=0 while rst is high, and 1 the cycle after rst falls.
- Latency: a result accepted in cycle N appears on the CDB in cycle N+1 at the earliest.
- Throughput: each unit sustains one result per cycle only while it wins every cycle. Otherwise the FIFO fills and fu_ready drops.
- No combinational path from fu_* to cdb_*. The only input-to-output paths are flush and rst, to cdb_valid_out and fu_ready.
- rst mid-operation: identical to flush, plus rr_ptr=0. Buffered results are lost.

## Test plan
- Single result:
  - Stimulus: after reset, unit 2 presents rob=5, rd=7, value=0xDEADBEEF in cycle 1.
  - Required: cycle 2 lane 0 shows valid=1, rob=5, rd=7, value=0xDEADBEEF; lane 1 valid=0; cycle 3 all lanes invalid; rr_ptr=3.
- All four units fire in one cycle (FU_COUNT=4, CDB_PORTS=2):
  - Stimulus: rr_ptr=0, each unit sends one result.
  - Required: cycle +1 broadcasts units 0 and 1 on lanes 0 and 1; cycle +2 broadcasts units 2 and 3; rr_ptr sequence is 2 then 0.
- Backpressure:
  - Stimulus: unit 0 holds fu_valid high with rob values 1, 2, 3 while units 1–3 stream continuously.
  - Required: fu_ready[0] goes 0 once unit 0 holds 2 entries; unit 0's results broadcast in order 1, 2, 3; none is lost or duplicated.
- Fairness:
  - Stimulus: all units stream continuously for 8 cycles.
  - Required: each unit is granted exactly 4 times.
- Flush:
  - Stimulus: units 0 and 1 each hold 2 entries; flush is pulsed for 1 cycle.
  - Required: cdb_valid_out=0 in the flush cycle and the cycle after; fu_ready=1 again the cycle after flush; rr_ptr=0.
- Reset mid-stream:
  - Stimulus: rst is asserted while FIFOs are non-empty.
  - Required: no broadcast while rst is high; after release, a new result from unit 3 appears 1 cycle later on lane 0.
